clk_compare_bank: RTL and testbench

Parametrised multi-channel compare-timer bank for the J1 SoC timer/counter subsystem. It watches a shared free-running `count` timebase and gives each of `N_CH` channels a programmable interval in one-shot or periodic mode. Each channel has a wrap-safe compare, a sticky interrupt-pending flag and a done flag. The pending flags are masked and ORed into a single `irq` line for the CPU interrupt controller.

---
 rtl/clk_cmp_pkg.sv | 18 +
 rtl/clk_cmp_channel.sv | 96 +++++++++
 rtl/clk_compare_bank.sv | 55 +++++
 tb/tb_clk_compare_bank.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/clk_cmp_pkg.sv
// Shared definitions for the compare-timer bank.
//   cmp_state_e   : per-channel FSM encoding (IDLE / ARMED / EXPIRED)
//   MODE_*        : values of the per-channel mode bit
//   CNT_W_DEFAULT : default timebase width
package clk_cmp_pkg;

  localparam int CNT_W_DEFAULT = 32;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_EXPIRED = 2'd2
  } cmp_state_e;

endpackage

// File: rtl/clk_cmp_channel.sv
// One compare channel: FSM, target register, wrap-safe compare,
// sticky pending flag and one-shot done flag.
// Ports:
//   clk, rst (async, active-low)
//   count    : shared timebase
//   en       : level enable; low returns the channel to IDLE
//   mode     : 0 one-shot, 1 periodic
//   limit    : interval
//   clr      : one-cycle pending clear (a simultaneous fire wins)
//   int_pend : sticky pending flag
//   done     : one-shot expired flag
module clk_cmp_channel
  import clk_cmp_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] count,
  input  logic             en,
  input  logic             mode,
  input  logic [CNT_W-1:0] limit,
  input  logic             clr,
  output logic             int_pend,
  output logic             done
);

  cmp_state_e       state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic             pend_q, pend_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] diff;
  logic             reached;

  // Wrap-safe "count has reached target": the modular distance is
  // non-negative when read as a signed value. Valid for intervals
  // below half the timebase range.
  assign diff    = count - target_q;
  assign reached = ~diff[CNT_W-1];

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    pend_d   = pend_q;
    done_d   = done_q;

    // Clear first so a fire in the same cycle overrides it.
    if (clr) pend_d = 1'b0;

    if (!en) begin
      state_d = ST_IDLE;
      pend_d  = 1'b0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          target_d = count + limit;
          state_d  = ST_ARMED;
        end
        ST_ARMED: begin
          if (reached) begin
            pend_d = 1'b1;
            if (mode == MODE_PERIODIC) begin
              // Advance from the old target so the period never drifts;
              // missed periods are caught up one limit per cycle.
              target_d = target_q + limit;
            end else begin
              state_d = ST_EXPIRED;
              done_d  = 1'b1;
            end
          end
        end
        ST_EXPIRED: done_d = 1'b1;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      pend_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      pend_q   <= pend_d;
      done_q   <= done_d;
    end
  end

  assign int_pend = pend_q;
  assign done     = done_q;

endmodule

// File: rtl/clk_compare_bank.sv
// Multi-channel compare-timer bank on a shared free-running timebase.
// Ports:
//   clk, rst (async, active-low)
//   count    [CNT_W]      : shared timebase
//   en, mode, clr, int_mask [N_CH] : per-channel controls
//   limit    [N_CH*CNT_W] : channel i in limit[i*CNT_W +: CNT_W]
//   int_pend, done [N_CH] : per-channel status
//   irq                   : registered OR of int_pend & int_mask
module clk_compare_bank
  import clk_cmp_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CNT_W-1:0]      count,
  input  logic [N_CH-1:0]       en,
  input  logic [N_CH-1:0]       mode,
  input  logic [N_CH*CNT_W-1:0] limit,
  input  logic [N_CH-1:0]       clr,
  input  logic [N_CH-1:0]       int_mask,
  output logic [N_CH-1:0]       int_pend,
  output logic [N_CH-1:0]       done,
  output logic                  irq
);

  logic irq_q, irq_d;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    clk_cmp_channel #(.CNT_W(CNT_W)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .count    (count),
      .en       (en[i]),
      .mode     (mode[i]),
      .limit    (limit[i*CNT_W +: CNT_W]),
      .clr      (clr[i]),
      .int_pend (int_pend[i]),
      .done     (done[i])
    );
  end

  always_comb begin
    irq_d = |(int_pend & int_mask);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) irq_q <= 1'b0;
    else      irq_q <= irq_d;
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_clk_compare_bank.sv
module tb_clk_compare_bank;

  localparam int N_CH  = 4;
  localparam int CNT_W = 32;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [CNT_W-1:0]      count;
  logic [N_CH-1:0]       en, mode, clr, int_mask;
  logic [N_CH*CNT_W-1:0] limit;
  logic [N_CH-1:0]       int_pend, done;
  logic                  irq;

  clk_compare_bank #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .count(count), .en(en), .mode(mode),
    .limit(limit), .clr(clr), .int_mask(int_mask),
    .int_pend(int_pend), .done(done), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  cnt;
    logic [127:0] lim;
    logic [3:0]   en, mode, clr, mask;
    logic [3:0]   pend, done;
    logic         irq;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(logic [31:0] c, logic [127:0] l, logic [3:0] e,
                              logic [3:0] m, logic [3:0] cl, logic [3:0] mk_,
                              logic [3:0] p, logic [3:0] d, logic i);
    vec_t v;
    v.cnt = c; v.lim = l; v.en = e; v.mode = m; v.clr = cl; v.mask = mk_;
    v.pend = p; v.done = d; v.irq = i;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One rising edge; outputs are read 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [127:0] lim_a, lim_b;
  logic [3:0]   prev_p, exp_p;

  initial begin
    lim_a = {32'd0, 32'd0, 32'd0, 32'd10};
    lim_b = {32'd0, 32'd0, 32'd5, 32'd0};

    // One-shot ch0, limit 10, armed at count 100.
    vecs.push_back(mk(100, lim_a, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0));
    vecs.push_back(mk(105, lim_a, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0));
    vecs.push_back(mk(109, lim_a, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0));
    vecs.push_back(mk(110, lim_a, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 1'b0));
    vecs.push_back(mk(111, lim_a, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 1'b1));
    vecs.push_back(mk(112, lim_a, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b1));
    vecs.push_back(mk(113, lim_a, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0));
    // Periodic ch1, limit 5, count stepping from 0; clr at 7, 11 and 15 (fire wins at 15).
    for (int c = 0; c <= 16; c++) begin
      logic [3:0] p, cl;
      logic       q;
      cl = (c == 7 || c == 11 || c == 15) ? 4'b0010 : 4'b0000;
      case (c)
        5, 6, 10, 15, 16: p = 4'b0010;
        default:          p = 4'b0000;
      endcase
      q = (c == 6 || c == 7 || c == 11 || c == 16);
      vecs.push_back(mk(c, lim_b, 4'b0010, 4'b0010, cl, 4'b0010, p, 4'b0000, q));
    end

    // Reset held with random inputs.
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      count = $urandom; en = 4'($urandom); mode = 4'($urandom);
      clr = 4'($urandom); int_mask = 4'($urandom);
      limit = {$urandom, $urandom, $urandom, $urandom};
      step();
      check("rst_pend", 32'(int_pend), 0);
      check("rst_done", 32'(done), 0);
      check("rst_irq", 32'(irq), 0);
    end
    en = '0; mode = '0; clr = '0; int_mask = '0; count = '0; limit = '0;
    step();
    rst = 1'b1;
    step();
    check("post_rst_pend", 32'(int_pend), 0);

    // Table-driven vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      count = vecs[i].cnt; limit = vecs[i].lim; en = vecs[i].en;
      mode = vecs[i].mode; clr = vecs[i].clr; int_mask = vecs[i].mask;
      step();
      check($sformatf("v%0d_pend", i), 32'(int_pend), 32'(vecs[i].pend));
      check($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].done));
      check($sformatf("v%0d_irq", i), 32'(irq), 32'(vecs[i].irq));
    end
    clr = '0;

    // Wrap-around: ch2 one-shot, limit 16, armed at 0xFFFF_FFF8 -> fires at 8.
    limit = {32'd0, 32'd16, 32'd0, 32'd0}; mode = 4'b0000; int_mask = 4'b0000;
    en = 4'b0100; count = 32'hFFFF_FFF8; step();
    count = 32'hFFFF_FFF9; step(); check("wrap_early", 32'(int_pend), 0);
    count = 32'h0000_0007; step(); check("wrap_7", 32'(int_pend), 0);
    count = 32'h0000_0008; step();
    check("wrap_fire_pend", 32'(int_pend), 32'h4);
    check("wrap_fire_done", 32'(done), 32'h4);
    en = 4'b0000; step(); check("wrap_off", 32'(int_pend), 0);

    // Mask and independence: one-shot limits 3/7/11/13, mask 0101.
    limit = {32'd13, 32'd11, 32'd7, 32'd3}; int_mask = 4'b0101; en = 4'b1111;
    prev_p = 4'b0000;
    for (int c = 0; c <= 14; c++) begin
      count = c;
      step();
      exp_p = {c >= 13, c >= 11, c >= 7, c >= 3};
      check($sformatf("ind_c%0d_pend", c), 32'(int_pend), 32'(exp_p));
      check($sformatf("ind_c%0d_irq", c), 32'(irq), 32'(|(prev_p & 4'b0101)));
      prev_p = exp_p;
    end
    en = 4'b0000; step(); step();
    check("ind_off_irq", 32'(irq), 0);

    // Periodic limit 0 on ch3 fires every armed cycle; clr never wins.
    limit = '0; mode = 4'b1000; int_mask = 4'b0000; en = 4'b1000;
    count = 50; step(); check("l0_arm", 32'(int_pend), 0);
    count = 51; step(); check("l0_first", 32'(int_pend), 32'h8);
    clr = 4'b1000;
    for (int c = 52; c < 56; c++) begin
      count = c; step();
      check($sformatf("l0_c%0d", c), 32'(int_pend), 32'h8);
    end
    clr = '0; en = '0; step(); check("l0_off", 32'(int_pend), 0);

    // Reset mid-ARMED, then fresh re-arm.
    limit = {32'd0, 32'd0, 32'd0, 32'd20}; mode = 4'b0001; int_mask = 4'b0001; en = 4'b0001;
    count = 200; step();
    count = 220; step(); check("mr_pend", 32'(int_pend), 32'h1);
    count = 221; step(); check("mr_irq", 32'(irq), 1);
    #2 rst = 1'b0;
    #1;
    check("mr_async_pend", 32'(int_pend), 0);
    check("mr_async_irq", 32'(irq), 0);
    step(); step();
    check("mr_held_pend", 32'(int_pend), 0);
    rst = 1'b1;
    count = 300; step(); check("mr_rearm", 32'(int_pend), 0);
    count = 319; step(); check("mr_319", 32'(int_pend), 0);
    count = 320; step(); check("mr_320_pend", 32'(int_pend), 32'h1);
    check("mr_320_irq", 32'(irq), 0);
    count = 321; step(); check("mr_321_irq", 32'(irq), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
